// File: rtl/led_channel_ctrl.sv
// Multi-channel LED/button controller: a shared tick prescaler, per-channel button
// synchronise/debounce, and per-channel OFF/ON/BLINK/BUTTON LED modes set by a write strobe.
module led_channel_ctrl #(
    parameter int NUM_CH          = 4,
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 1000,
    parameter int PERIOD_W        = 16,
    parameter int DEF_HALF_PERIOD = 500,
    parameter int DEBOUNCE_TICKS  = 8
) (
    input  logic                                          sys_clk_50m,
    input  logic                                          sys_rst,
    input  logic [NUM_CH-1:0]                             buttons,
    input  logic                                          cfg_wr,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [1:0]                                    cfg_mode,
    input  logic [PERIOD_W-1:0]                           cfg_half_period,
    output logic [NUM_CH-1:0]                             leds,
    output logic [NUM_CH-1:0]                             btn_pressed,
    output logic [NUM_CH-1:0]                             btn_press_evt
);
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W     = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_ON     = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_BUTTON = 2'd3
    } mode_e;

    logic [PRE_W-1:0]    presc;
    logic                tick;

    logic [NUM_CH-1:0]   sync_meta;
    logic [NUM_CH-1:0]   sync_btn;
    logic [NUM_CH-1:0]   stable;
    logic [NUM_CH-1:0]   stable_d;
    logic [DB_W-1:0]     db_cnt [NUM_CH];

    mode_e               mode          [NUM_CH];
    mode_e               mode_n        [NUM_CH];
    logic [PERIOD_W-1:0] half_period   [NUM_CH];
    logic [PERIOD_W-1:0] half_period_n [NUM_CH];
    logic [PERIOD_W-1:0] blink_cnt     [NUM_CH];
    logic [PERIOD_W-1:0] blink_cnt_n   [NUM_CH];
    logic [NUM_CH-1:0]   blink_st;
    logic [NUM_CH-1:0]   blink_st_n;
    logic [NUM_CH-1:0]   leds_n;

    // A half-period of 0 is treated as 1, so the terminal count never underflows.
    function automatic logic [PERIOD_W-1:0] blink_last(input logic [PERIOD_W-1:0] hp);
        return (hp == '0) ? '0 : hp - PERIOD_W'(1);
    endfunction

    assign tick = (presc == '0);

    always_ff @(posedge sys_clk_50m) begin
        if (sys_rst || tick) begin
            presc <= PRE_W'(TICK_DIV - 1);
        end else begin
            presc <= presc - PRE_W'(1);
        end
    end

    // The stable level only moves after DEBOUNCE_TICKS consecutive mismatching ticks.
    always_ff @(posedge sys_clk_50m) begin
        if (sys_rst) begin
            sync_meta     <= '1;
            sync_btn      <= '1;
            stable        <= '1;
            stable_d      <= '1;
            btn_press_evt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_meta     <= buttons;
            sync_btn      <= sync_meta;
            stable_d      <= stable;
            btn_press_evt <= stable_d & ~stable;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync_btn[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (tick) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_TICKS - 1)) begin
                        stable[i] <= sync_btn[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end
            end
        end
    end

    assign btn_pressed = ~stable;

    // A config write beats a coincident tick: the channel restarts its blink from zero.
    always_comb begin
        blink_st_n = blink_st;
        leds_n     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mode_n[i]        = mode[i];
            half_period_n[i] = half_period[i];
            blink_cnt_n[i]   = blink_cnt[i];
            if (cfg_wr && (cfg_ch == CH_W'(i))) begin
                mode_n[i]        = mode_e'(cfg_mode);
                half_period_n[i] = cfg_half_period;
                blink_cnt_n[i]   = '0;
                blink_st_n[i]    = 1'b0;
            end else if (mode[i] != MODE_BLINK) begin
                blink_cnt_n[i]   = '0;
                blink_st_n[i]    = 1'b0;
            end else if (tick) begin
                if (blink_cnt[i] == blink_last(half_period[i])) begin
                    blink_cnt_n[i] = '0;
                    blink_st_n[i]  = ~blink_st[i];
                end else begin
                    blink_cnt_n[i] = blink_cnt[i] + PERIOD_W'(1);
                end
            end
            case (mode[i])
                MODE_OFF:    leds_n[i] = 1'b0;
                MODE_ON:     leds_n[i] = 1'b1;
                MODE_BLINK:  leds_n[i] = blink_st[i];
                MODE_BUTTON: leds_n[i] = btn_pressed[i];
            endcase
        end
    end

    always_ff @(posedge sys_clk_50m) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode[i]        <= MODE_OFF;
                half_period[i] <= PERIOD_W'(DEF_HALF_PERIOD);
                blink_cnt[i]   <= '0;
            end
            blink_st <= '0;
            leds     <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode[i]        <= mode_n[i];
                half_period[i] <= half_period_n[i];
                blink_cnt[i]   <= blink_cnt_n[i];
            end
            blink_st <= blink_st_n;
            leds     <= leds_n;
        end
    end

endmodule

// File: tb/tb_led_channel_ctrl.sv
// Directed bench for led_channel_ctrl: table-driven config vectors plus hand-written
// sequences for blink timing, debounce, write/tick collision, out-of-range writes and reset.
module tb_led_channel_ctrl;
    localparam int          TICK_DIV    = 10;
    localparam logic [1:0]  MODE_OFF    = 2'd0;
    localparam logic [1:0]  MODE_ON     = 2'd1;
    localparam logic [1:0]  MODE_BLINK  = 2'd2;
    localparam logic [1:0]  MODE_BUTTON = 2'd3;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [3:0]  buttons;
    logic [2:0]  buttons3;
    logic        cfg_wr;
    logic        cfg_wr3;
    logic [1:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_half_period;
    logic [3:0]  leds;
    logic [3:0]  btn_pressed;
    logic [3:0]  btn_press_evt;
    logic [2:0]  leds3;
    logic [2:0]  btn_pressed3;
    logic [2:0]  btn_press_evt3;

    int cyc;
    int n_checks;
    int n_fail;

    typedef struct {
        logic [1:0]  ch;
        logic [1:0]  mode;
        logic [15:0] hp;
        logic [3:0]  exp_leds;
    } cfg_vec_t;

    cfg_vec_t vecs [8];

    always #5 clk = ~clk;

    // Bench-side cycle count since the last reset edge; ticks land on multiples of TICK_DIV.
    always @(posedge clk) begin
        if (sys_rst) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    led_channel_ctrl #(
        .NUM_CH(4), .CLK_HZ(100), .TICK_HZ(10), .PERIOD_W(16),
        .DEF_HALF_PERIOD(500), .DEBOUNCE_TICKS(3)
    ) u_dut (
        .sys_clk_50m(clk), .sys_rst(sys_rst), .buttons(buttons),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_half_period(cfg_half_period), .leds(leds),
        .btn_pressed(btn_pressed), .btn_press_evt(btn_press_evt)
    );

    led_channel_ctrl #(
        .NUM_CH(3), .CLK_HZ(100), .TICK_HZ(10), .PERIOD_W(16),
        .DEF_HALF_PERIOD(500), .DEBOUNCE_TICKS(3)
    ) u_dut3 (
        .sys_clk_50m(clk), .sys_rst(sys_rst), .buttons(buttons3),
        .cfg_wr(cfg_wr3), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_half_period(cfg_half_period), .leds(leds3),
        .btn_pressed(btn_pressed3), .btn_press_evt(btn_press_evt3)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drives a one-cycle write; returns at the negedge right after the write edge.
    task automatic apply_stimulus(input logic to_small, input logic [1:0] ch, input logic [1:0] mode,
                                  input logic [15:0] hp);
        cfg_ch          = ch;
        cfg_mode        = mode;
        cfg_half_period = hp;
        if (to_small) cfg_wr3 = 1'b1;
        else          cfg_wr  = 1'b1;
        @(negedge clk);
        cfg_wr  = 1'b0;
        cfg_wr3 = 1'b0;
    endtask

    // Expected blink LED after cycle c, for a write landing on edge w with half-period hp.
    function automatic logic blink_exp(input int c, input int w, input int hp);
        int h;
        int t;
        h = (hp < 1) ? 1 : hp;
        t = (w / TICK_DIV + 1) * TICK_DIV + (h - 1) * TICK_DIV;
        if (c <= t) return 1'b0;
        return (((c - t - 1) / (TICK_DIV * h)) % 2) == 0;
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int w2;
        int p;
        int f_press;
        int f_rel;
        logic exp_p;
        logic [3:0] prev_leds;

        sys_rst = 1'b1; buttons = '1; buttons3 = '1;
        cfg_wr = 1'b0; cfg_wr3 = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_half_period = '0;
        n_checks = 0; n_fail = 0;

        vecs[0] = '{ch: 2'd0, mode: MODE_ON,     hp: 16'd5, exp_leds: 4'b0001};
        vecs[1] = '{ch: 2'd3, mode: MODE_ON,     hp: 16'd0, exp_leds: 4'b1001};
        vecs[2] = '{ch: 2'd2, mode: MODE_BUTTON, hp: 16'd7, exp_leds: 4'b1001};
        vecs[3] = '{ch: 2'd0, mode: MODE_OFF,    hp: 16'd1, exp_leds: 4'b1000};
        vecs[4] = '{ch: 2'd1, mode: MODE_ON,     hp: 16'd2, exp_leds: 4'b1010};
        vecs[5] = '{ch: 2'd3, mode: MODE_OFF,    hp: 16'd3, exp_leds: 4'b0010};
        vecs[6] = '{ch: 2'd1, mode: MODE_OFF,    hp: 16'd4, exp_leds: 4'b0000};
        vecs[7] = '{ch: 2'd2, mode: MODE_OFF,    hp: 16'd9, exp_leds: 4'b0000};

        repeat (3) step();
        sys_rst = 1'b0;
        check_output("reset_leds", leds, 4'b0000);
        check_output("reset_pressed", btn_pressed, 4'b0000);
        check_output("reset_evt", btn_press_evt, 4'b0000);
        check_output("reset_leds3", leds3, 3'b000);

        $display("[TB] idle 200 cycles");
        for (int n = 0; n < 200; n++) begin
            step();
            check_output("idle_leds", leds, 4'b0000);
            check_output("idle_pressed", btn_pressed, 4'b0000);
            check_output("idle_evt", btn_press_evt, 4'b0000);
        end

        $display("[TB] config vector table");
        prev_leds = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, vecs[i].ch, vecs[i].mode, vecs[i].hp);
            check_output($sformatf("cfg_vec%0d_hold", i), leds, prev_leds);
            step();
            check_output($sformatf("cfg_vec%0d_leds", i), leds, vecs[i].exp_leds);
            check_output($sformatf("cfg_vec%0d_pressed", i), btn_pressed, 4'b0000);
            prev_leds = vecs[i].exp_leds;
        end

        $display("[TB] ch1 blink half_period 2 then 0");
        apply_stimulus(1'b0, 2'd1, MODE_BLINK, 16'd2);
        w = cyc;
        for (int n = 0; n < 100; n++) begin
            step();
            check_output("blink_hp2", leds, {2'b00, blink_exp(cyc, w, 2), 1'b0});
        end
        apply_stimulus(1'b0, 2'd1, MODE_BLINK, 16'd0);
        w = cyc;
        for (int n = 0; n < 50; n++) begin
            step();
            check_output("blink_hp0", leds, {2'b00, blink_exp(cyc, w, 0), 1'b0});
        end
        apply_stimulus(1'b0, 2'd1, MODE_OFF, 16'd0);

        $display("[TB] ch2 button press and release");
        apply_stimulus(1'b0, 2'd2, MODE_BUTTON, 16'd0);
        step();
        buttons[2] = 1'b0;
        p       = cyc;
        f_press = ((p + 3 + TICK_DIV - 1) / TICK_DIV) * TICK_DIV;
        f_rel   = ((p + 63 + TICK_DIV - 1) / TICK_DIV) * TICK_DIV;
        for (int n = 0; n < 110; n++) begin
            step();
            exp_p = (cyc >= f_press + 20) && (cyc < f_rel + 20);
            check_output("btn_pressed", btn_pressed, {1'b0, exp_p, 2'b00});
            check_output("btn_evt", btn_press_evt, {1'b0, (cyc == f_press + 21), 2'b00});
            check_output("btn_leds", leds, {1'b0, (cyc >= f_press + 21) && (cyc < f_rel + 21), 2'b00});
            if (cyc == p + 60) buttons[2] = 1'b1;
        end

        $display("[TB] ch0 bounce");
        buttons[0] = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            step();
            check_output("bounce_pressed", btn_pressed, 4'b0000);
            check_output("bounce_evt", btn_press_evt, 4'b0000);
            if ((n % 10 == 0) && (n < 100)) buttons[0] = ~buttons[0];
        end
        buttons[0] = 1'b1;

        $display("[TB] ch3 write colliding with tick");
        for (int g = 0; (g < 10) && ((cyc % TICK_DIV) != TICK_DIV - 1); g++) step();
        apply_stimulus(1'b0, 2'd3, MODE_BLINK, 16'd3);
        w = cyc;
        for (int n = 0; n < 49; n++) begin
            step();
            check_output("collide_pre", leds, {blink_exp(cyc, w, 3), 3'b000});
        end
        apply_stimulus(1'b0, 2'd3, MODE_BLINK, 16'd3);
        w2 = cyc;
        check_output("collide_edge", leds, {blink_exp(w2, w, 3), 3'b000});
        for (int n = 0; n < 70; n++) begin
            step();
            check_output("collide_post", leds, {blink_exp(cyc, w2, 3), 3'b000});
        end
        apply_stimulus(1'b0, 2'd3, MODE_OFF, 16'd0);

        $display("[TB] out-of-range channel on 3-channel instance");
        apply_stimulus(1'b1, 2'd0, MODE_ON, 16'd0);
        step();
        check_output("oor_setup", leds3, 3'b001);
        apply_stimulus(1'b1, 2'd3, MODE_OFF, 16'd0);
        step();
        check_output("oor_off", leds3, 3'b001);
        apply_stimulus(1'b1, 2'd3, MODE_ON, 16'd0);
        step();
        check_output("oor_on", leds3, 3'b001);
        apply_stimulus(1'b1, 2'd3, MODE_BLINK, 16'd1);
        repeat (30) step();
        check_output("oor_blink", leds3, 3'b001);
        apply_stimulus(1'b1, 2'd2, MODE_ON, 16'd0);
        step();
        check_output("oor_valid", leds3, 3'b101);

        $display("[TB] reset mid-blink and mid-debounce");
        apply_stimulus(1'b0, 2'd0, MODE_ON, 16'd0);
        apply_stimulus(1'b0, 2'd1, MODE_BLINK, 16'd2);
        buttons[3] = 1'b0;
        repeat (45) step();
        check_output("pre_rst_pressed3", btn_pressed[3], 1'b1);
        buttons[2] = 1'b0;
        repeat (20) step();
        check_output("pre_rst_led0", leds[0], 1'b1);
        sys_rst = 1'b1;
        step();
        check_output("rst_leds", leds, 4'b0000);
        check_output("rst_pressed", btn_pressed, 4'b0000);
        check_output("rst_evt", btn_press_evt, 4'b0000);
        check_output("rst_leds3", leds3, 3'b000);
        check_output("rst_pressed3", btn_pressed3, 3'b000);
        check_output("rst_evt3", btn_press_evt3, 3'b000);
        sys_rst = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            check_output("post_rst_pressed", btn_pressed, (cyc >= 30) ? 4'b1100 : 4'b0000);
            check_output("post_rst_evt", btn_press_evt, (cyc == 31) ? 4'b1100 : 4'b0000);
            check_output("post_rst_leds", leds, 4'b0000);
        end
        buttons = '1;
        apply_stimulus(1'b0, 2'd1, MODE_BLINK, 16'd2);
        w = cyc;
        for (int n = 0; n < 60; n++) begin
            step();
            check_output("post_rst_blink", leds, {2'b00, blink_exp(cyc, w, 2), 1'b0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
